// File: rtl/rx_frame_fifo_pkg.sv
// Shared definitions for the RX frame FIFO: default geometry, flag
// thresholds and the write-side state encoding.
package rx_frame_fifo_pkg;

    localparam int unsigned RX_DATA_FIFO_AWIDTH = 9;
    localparam int unsigned RX_DATA_FIFO_DWIDTH = 64;
    localparam int unsigned RX_DATA_FIFO_SWIDTH = 8;

    localparam int unsigned RX_FIFO_ALMOST_EMPTY_THRESH = 4;
    localparam int unsigned RX_FIFO_ALMOST_FULL_MARGIN  = 4;

    // Write-side frame tracking states
    typedef enum logic [1:0] {
        WR_IDLE     = 2'd0,
        WR_IN_FRAME = 2'd1,
        WR_DISCARD  = 2'd2
    } wr_state_e;

    // Default almost-full level: DEPTH minus a fixed margin
    function automatic int unsigned almost_full_default(input int unsigned aw);
        return (32'd1 << aw) - RX_FIFO_ALMOST_FULL_MARGIN;
    endfunction

endpackage

// File: rtl/rx_frame_fifo_mem.sv
// Storage array for rx_frame_fifo: one synchronous write port, one
// combinational read port. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write word
//   raddr  - read address
//   rdata  - read word (combinational from raddr)
module rx_frame_fifo_mem
    import rx_frame_fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = RX_DATA_FIFO_DWIDTH + RX_DATA_FIFO_SWIDTH + 1,
    parameter int unsigned AWIDTH = RX_DATA_FIFO_AWIDTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive frame FIFO. Words of a frame are written at a
// speculative pointer and only become visible to the reader once the frame's
// last word arrives without error; errored or oversize frames are rolled back.
// Read side is first-word-fall-through.
// Optional feature: define RX_FRAME_FIFO_STATS_EN to add a saturating
// drop_count output.
// Ports:
//   clk_156m25, reset_156m25 - clock, synchronous active-high reset
//   wr_en/wr_data/wr_status/wr_eop/wr_err - write side, wr_err valid with wr_eop
//   rd_en/rd_data/rd_status/rd_eop - FWFT read side
//   empty/almost_empty/full/almost_full - level flags
//   frame_count - committed frames held; drop_pulse - one-cycle drop strobe
//   drop_count - (stats build only) number of dropped frames
module rx_frame_fifo
    import rx_frame_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH              = RX_DATA_FIFO_DWIDTH,
    parameter int unsigned SWIDTH              = RX_DATA_FIFO_SWIDTH,
    parameter int unsigned AWIDTH              = RX_DATA_FIFO_AWIDTH,
    parameter int unsigned ALMOST_EMPTY_THRESH = RX_FIFO_ALMOST_EMPTY_THRESH,
    parameter int unsigned ALMOST_FULL_THRESH  = almost_full_default(AWIDTH)
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [SWIDTH-1:0] wr_status,
    input  logic              wr_eop,
    input  logic              wr_err,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic [SWIDTH-1:0] rd_status,
    output logic              rd_eop,
    output logic              empty,
    output logic              almost_empty,
    output logic              full,
    output logic              almost_full,
    output logic [AWIDTH:0]   frame_count,
`ifdef RX_FRAME_FIFO_STATS_EN
    output logic [31:0]       drop_count,
`endif
    output logic              drop_pulse
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam int unsigned PW    = AWIDTH + 1;
    localparam int unsigned MW    = DWIDTH + SWIDTH + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cm_ptr;
    logic [PW-1:0] rd_ptr;
    wr_state_e     state;

    logic [PW-1:0] occ_c;
    logic [PW-1:0] avail_c;
    logic          store_c;
    logic          commit_c;
    logic          pop_c;
    logic [MW-1:0] mem_rdata;

    // Level flags straight from the registered pointers
    assign occ_c        = wr_ptr - rd_ptr;
    assign avail_c      = cm_ptr - rd_ptr;
    assign empty        = (rd_ptr == cm_ptr);
    assign full         = (occ_c == PW'(DEPTH));
    assign almost_empty = (32'(avail_c) <= ALMOST_EMPTY_THRESH);
    assign almost_full  = (32'(occ_c) >= ALMOST_FULL_THRESH);

    // An errored last word may still be written; the rollback discards it
    assign store_c  = wr_en && !full && (state != WR_DISCARD);
    assign commit_c = store_c && wr_eop && !wr_err;
    assign pop_c    = rd_en && !empty;

    rx_frame_fifo_mem #(
        .WIDTH  (MW),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (clk_156m25),
        .we    (store_c),
        .waddr (wr_ptr[AWIDTH-1:0]),
        .wdata ({wr_status, wr_eop, wr_data}),
        .raddr (rd_ptr[AWIDTH-1:0]),
        .rdata (mem_rdata)
    );

    assign {rd_status, rd_eop, rd_data} = mem_rdata;

    // Pointer, write FSM and frame counter
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= WR_IDLE;
            frame_count <= '0;
            drop_pulse  <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;

            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case (state)
                WR_IDLE, WR_IN_FRAME: begin
                    if (wr_en) begin
                        if (wr_eop) begin
                            // Every last word either commits or drops the frame
                            if (commit_c) begin
                                wr_ptr <= wr_ptr + PW'(1);
                                cm_ptr <= wr_ptr + PW'(1);
                            end else begin
                                wr_ptr     <= cm_ptr;
                                drop_pulse <= 1'b1;
                            end
                            state <= WR_IDLE;
                        end else if (full) begin
                            state <= WR_DISCARD;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                            state  <= WR_IN_FRAME;
                        end
                    end
                end
                WR_DISCARD: begin
                    if (wr_en && wr_eop) begin
                        wr_ptr     <= cm_ptr;
                        drop_pulse <= 1'b1;
                        state      <= WR_IDLE;
                    end
                end
                default: state <= WR_IDLE;
            endcase

            if (commit_c && !(pop_c && rd_eop)) begin
                frame_count <= frame_count + PW'(1);
            end else if (!commit_c && pop_c && rd_eop) begin
                frame_count <= frame_count - PW'(1);
            end
        end
    end

`ifdef RX_FRAME_FIFO_STATS_EN
    // Saturating count of dropped frames
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            drop_count <= '0;
        end else if (drop_pulse && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Self-checking bench for rx_frame_fifo (AWIDTH=4, DEPTH=16) against a
// queue-based frame model: committed words, pending words, discard flag.
module tb_rx_frame_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned EW    = DW + SW + 1;

    typedef logic [EW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_status;
    logic          wr_eop;
    logic          wr_err;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic [SW-1:0] rd_status;
    logic          rd_eop;
    logic          empty;
    logic          almost_empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   frame_count;
    logic          drop_pulse;
`ifdef RX_FRAME_FIFO_STATS_EN
    logic [31:0]   drop_count;
`endif

    always #5 clk = ~clk;

    rx_frame_fifo #(
        .DWIDTH (DW),
        .SWIDTH (SW),
        .AWIDTH (AW)
    ) dut (
        .clk_156m25   (clk),
        .reset_156m25 (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_status    (wr_status),
        .wr_eop       (wr_eop),
        .wr_err       (wr_err),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_status    (rd_status),
        .rd_eop       (rd_eop),
        .empty        (empty),
        .almost_empty (almost_empty),
        .full         (full),
        .almost_full  (almost_full),
        .frame_count  (frame_count),
`ifdef RX_FRAME_FIFO_STATS_EN
        .drop_count   (drop_count),
`endif
        .drop_pulse   (drop_pulse)
    );

    // Reference model
    ent_t        cq[$];
    ent_t        pq[$];
    bit          m_discard;
    bit          m_drop_pulse;
    int unsigned m_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_frames();
        int   n = 0;
        ent_t h;
        foreach (cq[i]) begin
            h = cq[i];
            if (h[DW]) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        cq.delete();
        pq.delete();
        m_discard    = 1'b0;
        m_drop_pulse = 1'b0;
        m_drop_cnt   = 0;
    endtask

    // Apply one clock edge of the frame rules to the model
    task automatic model_step();
        int   occ;
        bit   fullp;
        bit   dropped;
        ent_t e;
        occ     = cq.size() + pq.size();
        fullp   = (occ == DEPTH);
        dropped = 1'b0;
        if (m_drop_pulse && m_drop_cnt != 32'hFFFF_FFFF) m_drop_cnt++;
        if (rd_en && cq.size() > 0) void'(cq.pop_front());
        if (wr_en) begin
            e = {wr_status, wr_eop, wr_data};
            if (m_discard) begin
                if (wr_eop) begin
                    dropped = 1'b1;
                    pq.delete();
                    m_discard = 1'b0;
                end
            end else if (fullp) begin
                if (wr_eop) begin
                    dropped = 1'b1;
                    pq.delete();
                end else begin
                    m_discard = 1'b1;
                end
            end else if (wr_eop) begin
                if (wr_err) begin
                    dropped = 1'b1;
                    pq.delete();
                end else begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    cq.push_back(e);
                    pq.delete();
                end
            end else begin
                pq.push_back(e);
            end
        end
        m_drop_pulse = dropped;
    endtask

    task automatic check_outputs();
        int   occ;
        ent_t h;
        occ = cq.size() + pq.size();
        check_val("empty",        64'(empty),        64'(cq.size() == 0));
        check_val("almost_empty", 64'(almost_empty), 64'(cq.size() <= 4));
        check_val("full",         64'(full),         64'(occ == DEPTH));
        check_val("almost_full",  64'(almost_full),  64'(occ >= DEPTH - 4));
        check_val("frame_count",  64'(frame_count),  64'(m_frames()));
        check_val("drop_pulse",   64'(drop_pulse),   64'(m_drop_pulse));
`ifdef RX_FRAME_FIFO_STATS_EN
        check_val("drop_count",   64'(drop_count),   64'(m_drop_cnt));
`endif
        if (cq.size() > 0) begin
            h = cq[0];
            check_val("rd_data",   64'(rd_data),   64'(h[DW-1:0]));
            check_val("rd_eop",    64'(rd_eop),    64'(h[DW]));
            check_val("rd_status", 64'(rd_status), 64'(h[EW-1:DW+1]));
        end
    endtask

    task automatic cycle(input bit we, input bit eop, input bit err, input bit re);
        wr_en     = we;
        wr_eop    = eop;
        wr_err    = err;
        rd_en     = re;
        wr_data   = DW'($urandom);
        wr_status = SW'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        wr_eop = 1'b0;
        wr_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_val("rst_empty",        64'(empty),        64'd1);
        check_val("rst_almost_empty", 64'(almost_empty), 64'd1);
        check_val("rst_full",         64'(full),         64'd0);
        check_val("rst_almost_full",  64'(almost_full),  64'd0);
        check_val("rst_frame_count",  64'(frame_count),  64'd0);
        check_val("rst_drop_pulse",   64'(drop_pulse),   64'd0);
    endtask

    task automatic write_frame(input int n, input bit err);
        for (int i = 0; i < n; i++) cycle(1'b1, i == n - 1, err && (i == n - 1), 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        wr_status = '0;
        wr_eop    = 1'b0;
        wr_err    = 1'b0;
        rd_en     = 1'b0;
        model_reset();
        do_reset();

        // Good 5-word frame stays invisible until committed
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            check_val("sf_empty_mid", 64'(empty), 64'd1);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("sf_empty_after_eop", 64'(empty),       64'd0);
        check_val("sf_frames_after_eop", 64'(frame_count), 64'd1);
        pop_n(5);
        check_val("sf_frames_drained", 64'(frame_count), 64'd0);

        // Errored frame is rolled back, next good frame intact
        write_frame(5, 1'b1);
        check_val("err_drop_pulse", 64'(drop_pulse), 64'd1);
        check_val("err_empty",      64'(empty),      64'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("err_pulse_one_cycle", 64'(drop_pulse), 64'd0);
        write_frame(3, 1'b0);
        pop_n(3);

        // Oversize frame fills the FIFO, then is discarded
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, i == 19, 1'b0, 1'b0);
            if (i == 15) check_val("big_full_at_16", 64'(full), 64'd1);
        end
        check_val("big_drop_pulse", 64'(drop_pulse),  64'd1);
        check_val("big_full_after", 64'(full),        64'd0);
        check_val("big_af_after",   64'(almost_full), 64'd0);
        check_val("big_frames",     64'(frame_count), 64'd0);

        // Commit of B coincides with pop of A's last word
        write_frame(2, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check_val("cp_frames_same", 64'(frame_count), 64'd1);
        pop_n(2);

        // Reset in the middle of a frame
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        write_frame(2, 1'b0);
        check_val("mr_frames", 64'(frame_count), 64'd1);
        pop_n(3);

        // Randomized traffic with alternating reader pressure
        for (int i = 0; i < 4000; i++) begin
            int rd_pct;
            rd_pct = ((i / 400) % 2 == 0) ? 15 : 85;
            if ($urandom_range(999) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(99) < 70, $urandom_range(99) < 18,
                      $urandom_range(99) < 20, $urandom_range(99) < rd_pct);
            end
        end

        // Drain
        for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("final_empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
